// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op/state encodings and latencies for the MDU controller (MDU_MADD_EN adds accumulate ops)
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    // Ops that occupy the unit for the multiply latency.
    function automatic logic is_mul_op(input logic [3:0] code);
`ifdef MDU_MADD_EN
        return code inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        return code inside {MDU_MULT, MDU_MULTU};
`endif
    endfunction

    // Ops that occupy the unit for the divide latency.
    function automatic logic is_div_op(input logic [3:0] code);
        return code inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational HI/LO result generator for mult/div (and madd/msub when MDU_MADD_EN)
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo,
    output logic        pend_we
);
    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        signed_div;
    logic        q_neg;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both DIV and DIVU; signed divide works on
    // magnitudes and fixes signs afterwards. A zero divisor is forced to 1 so
    // the divider never sees it; the result is discarded via pend_we anyway.
    assign signed_div = (op == MDU_DIV);
    assign div_n      = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign div_d      = (b == 32'd0) ? 32'd1 :
                        ((signed_div && b[31]) ? (~b + 32'd1) : b);
    assign q_mag      = div_n / div_d;
    assign r_mag      = div_n % div_d;
    assign q_neg      = signed_div && (a[31] ^ b[31]);

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    // Select the result the op will leave in HI/LO.
    always_comb begin
        pend_hi = 32'd0;
        pend_lo = 32'd0;
        pend_we = 1'b0;
        case (op)
            MDU_MULT: begin
                {pend_hi, pend_lo} = sprod;
                pend_we            = 1'b1;
            end
            MDU_MULTU: begin
                {pend_hi, pend_lo} = uprod;
                pend_we            = 1'b1;
            end
            MDU_DIV: begin
                pend_lo = q_neg ? (~q_mag + 32'd1) : q_mag;
                pend_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
                pend_we = (b != 32'd0);
            end
            MDU_DIVU: begin
                pend_lo = q_mag;
                pend_hi = r_mag;
                pend_we = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                {pend_hi, pend_lo} = {hi, lo} + sprod;
                pend_we            = 1'b1;
            end
            MDU_MADDU: begin
                {pend_hi, pend_lo} = {hi, lo} + uprod;
                pend_we            = 1'b1;
            end
            MDU_MSUB: begin
                {pend_hi, pend_lo} = {hi, lo} - sprod;
                pend_we            = 1'b1;
            end
            MDU_MSUBU: begin
                {pend_hi, pend_lo} = {hi, lo} - uprod;
                pend_we            = 1'b1;
            end
`endif
            default: begin
                pend_we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO (optional madd/msub via MDU_MADD_EN)
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    mdu_state_e       state;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_we;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_we;
    logic             accept;
    logic             launch;
    logic             commit;
    logic             wr_hi;
    logic             wr_lo;

    mdu_calc u_calc (
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .pend_hi (calc_hi),
        .pend_lo (calc_lo),
        .pend_we (calc_we)
    );

    // An issue while RUN is dropped; the stall unit keeps that from happening.
    assign accept = start && !kill && (state == S_IDLE);
    assign busy   = (state == S_RUN);

    // Next state, counter and write strobes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        launch  = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op(op)) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        launch  = 1'b1;
                    end else if (is_div_op(op)) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                        launch  = 1'b1;
                    end else begin
                        wr_hi = (op == MDU_MTHI);
                        wr_lo = (op == MDU_MTLO);
                    end
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                    commit  = pend_we;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Counter, pending result capture and HI/LO update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            cnt <= cnt_d;
            if (launch) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
                pend_we <= calc_we;
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (wr_hi) begin
                hi <= a;
            end
            if (wr_lo) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl (MDU_MADD_EN adds accumulate vectors)
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        kill  = 1'b0;
    logic [3:0]  op    = 4'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mh = 32'd0;
    logic [31:0] ml = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        k;
        int          n;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[$];

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic k, input int n, input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.k = k; v.n = n; v.eh = eh; v.el = el;
        vecs.push_back(v);
    endtask

    // Called at a negedge; issues one op and returns at the first negedge with busy low.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic k, output int n);
        bit done;
        done  = 0;
        op    = o;
        a     = x;
        b     = y;
        kill  = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 4'd0;
        n     = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1;
        end
    endtask

    // Architectural effect of one issue, from the instruction-set definition.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic k, output int n);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        n  = 0;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        if (k) return;
        case (o)
            4'd1: begin p = sa * sb; {mh, ml} = p; n = MC; end
            4'd2: begin p = {32'd0, x} * {32'd0, y}; {mh, ml} = p; n = MC; end
            4'd3: begin
                n = DC;
                if (y != 0) begin
                    q = sa / sb; r = sa % sb;
                    ml = q[31:0]; mh = r[31:0];
                end
            end
            4'd4: begin
                n = DC;
                if (y != 0) begin ml = x / y; mh = x % y; end
            end
            4'd5: mh = x;
            4'd6: ml = x;
`ifdef MDU_MADD_EN
            4'd7:  begin p = sa * sb; {mh, ml} = {mh, ml} + p; n = MC; end
            4'd8:  begin p = {32'd0, x} * {32'd0, y}; {mh, ml} = {mh, ml} + p; n = MC; end
            4'd9:  begin p = sa * sb; {mh, ml} = {mh, ml} - p; n = MC; end
            4'd10: begin p = {32'd0, x} * {32'd0, y}; {mh, ml} = {mh, ml} - p; n = MC; end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;

        add(4'd1,  32'hFFFF_FFFF, 32'd2,         0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add(4'd2,  32'hFFFF_FFFF, 32'd2,         0, MC, 32'h0000_0001, 32'hFFFF_FFFE);
        add(4'd6,  32'h0000_1234, 32'd0,         0, 0,  32'h0000_0001, 32'h0000_1234);
        add(4'd3,  32'hFFFF_FFF9, 32'd2,         0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add(4'd4,  32'd5,         32'd0,         0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add(4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 0, DC, 32'h0000_0000, 32'h8000_0000);
        add(4'd1,  32'd3,         32'd3,         1, 0,  32'h0000_0000, 32'h8000_0000);
        add(4'd5,  32'h0000_DEAD, 32'd0,         1, 0,  32'h0000_0000, 32'h8000_0000);
        add(4'd5,  32'hCAFE_0000, 32'd0,         0, 0,  32'hCAFE_0000, 32'h8000_0000);
        add(4'd0,  32'd9,         32'd9,         0, 0,  32'hCAFE_0000, 32'h8000_0000);
        add(4'd12, 32'd9,         32'd9,         0, 0,  32'hCAFE_0000, 32'h8000_0000);
        add(4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, MC, 32'hFFFF_FFFE, 32'h0000_0001);
        add(4'd4,  32'd100,       32'd7,         0, DC, 32'h0000_0002, 32'h0000_000E);
        add(4'd3,  32'd7,         32'hFFFF_FFFE, 0, DC, 32'h0000_0001, 32'hFFFF_FFFD);
`ifdef MDU_MADD_EN
        add(4'd5,  32'd0,         32'd0,         0, 0,  32'h0000_0000, 32'hFFFF_FFFD);
        add(4'd6,  32'hFFFF_FFFF, 32'd0,         0, 0,  32'h0000_0000, 32'hFFFF_FFFF);
        add(4'd8,  32'd1,         32'd1,         0, MC, 32'h0000_0001, 32'h0000_0000);
        add(4'd9,  32'd1,         32'd1,         0, MC, 32'h0000_0000, 32'hFFFF_FFFF);
`else
        add(4'd7,  32'd5,         32'd5,         0, 0,  32'h0000_0001, 32'hFFFF_FFFD);
`endif

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].k, n);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(n), 64'(vecs[i].n));
            chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].eh, vecs[i].el});
            mh = vecs[i].eh;
            ml = vecs[i].el;
        end

        // Issue strobe must not reach busy combinationally; a second start
        // (with kill) during RUN is ignored and the in-flight op completes.
        op = 4'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        #1;
        chk("no_comb_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        op = 4'd5; a = 32'h77; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        begin
            bit done;
            done = 0;
            n = 0;
            for (int i = 0; i < 64 && !done; i++) begin
                @(negedge clk);
                if (busy) n++;
                else done = 1;
            end
        end
        kill = 1'b0;
        chk("ignored_start_busy", 64'(n), 64'(MC - 1));
        chk("ignored_start_hilo", {hi, lo}, {32'd0, 32'd15});

        // Asynchronous reset in the middle of RUN discards the pending result.
        op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        chk("midrun_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_hilo", {hi, lo}, 64'd0);
        mh = 32'd0;
        ml = 32'd0;

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            logic        k;
            int          en;
            o = 4'($urandom_range(0, 12));
            x = pick();
            y = pick();
            k = ($urandom_range(0, 7) == 0);
            model_apply(o, x, y, k, en);
            run_op(o, x, y, k, n);
            chk($sformatf("rand%0d_op%0d_busy", i, o), 64'(n), 64'(en));
            chk($sformatf("rand%0d_op%0d_hilo", i, o), {hi, lo}, {mh, ml});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller for the 5-stage MIPS32 pipeline, located in the E stage.
- Accepts mult/div/mthi/mtlo issue strobes and owns the HI/LO architectural registers.
- Sequences fixed-latency operations and drives `busy` to the hazard/stall unit.
- The stall unit stalls mfhi/mflo/mult/div in D while `busy` or `start` is high.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  E-stage issue strobe for any MDU op, 1-cycle pulse.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-10 reserved for the optional feature.
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- kill  input  1  E-stage flush (exception/interrupt); suppresses the issue in the same cycle.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, reset=0): state IDLE, counter 0; busy=0, hi=0, lo=0, pending regs 0. Abandons any in-flight op with no commit.
- Accept condition: start && !kill && state==IDLE. In any other state, start is ignored and HI/LO are unchanged; the stall unit guarantees this never happens, and the bench flags it.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU. The counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - RUN decrements the counter each cycle. RUN -> IDLE when counter==0.
- Result timing:
  - The result is computed from a/b at issue and registered into pend_hi/pend_lo (plus a pend_we flag).
  - HI/LO take pending values on the RUN->IDLE edge.
- Timing for issue at cycle t with N cycles:
  - busy=1 in cycles t+1 .. t+N.
  - New hi/lo visible from t+N+1, the same cycle busy falls.
  - A following op can issue at t+N+1.
- MULT: {HI,LO} = signed a*b, 64-bit. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0, DIV/DIVU): busy still asserted for DIV_CYCLES; pend_we=0, so HI/LO are unchanged.
- MTHI/MTLO: when accepted, write a to HI/LO at the next edge. No busy; the FSM stays IDLE.
- op NONE or reserved (without the feature): no effect.
- kill during RUN has no effect; the in-flight op completes, since it was issued by an older committed instruction.
- busy depends only on state; there is no combinational path from start.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined:
  - Ops 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are accepted with MULT_CYCLES latency.
  - Pending = {HI,LO} ± product, where {HI,LO} is sampled at issue and arithmetic is 64-bit wrap-around.
  - Signed product for MADD/MSUB; unsigned for MADDU/MSUBU.
- When undefined: ops 7-10 are treated as NONE, and no accumulate adder is synthesized.

Decomposition:
- Shared package holds:
  - op encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU;
  - FSM state encodings S_IDLE, S_RUN;
  - default latencies.
- One sub-module, mdu_calc: purely combinational.
  - Inputs: op, a, b, hi, lo.
  - Outputs: pend_hi, pend_lo, pend_we.
- mdu_ctrl keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset: with reset=0 mid-RUN (MULT issued, 2 cycles elapsed), busy=0 and hi=lo=0 immediately. After release, HI/LO stay 0.
- MULT: a=0xFFFFFFFF, b=2, start at t. Required: busy high t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU with the same operands: hi=0x00000001, lo=0xFFFFFFFE at t+6. A back-to-back MTLO a=0x1234 at t+6 gives lo=0x1234 at t+7.
- DIV: a=-7 (0xFFFFFFF9), b=2. Required: busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with b=0: busy 10 cycles, HI/LO unchanged.
- kill: start=1, kill=1, op=MULT gives busy stays 0 and HI/LO unchanged. MTHI with kill=1 gives no write.
- MDU_MADD_EN: preload HI=0, LO=0xFFFFFFFF; MADDU a=1, b=1. Required: after 5 cycles hi=1, lo=0. Without the macro, op 7 produces no busy and no change.
